// File: rtl/sfm_pkg.sv
// Shared types and elaboration helpers for the softmax (SFM) datapath blocks.
package sfm_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } expu_ctrl_state_e;

   // Ceiling log2 with a floor of 1, so derived counters never collapse to zero width.
   function automatic int sfm_clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

   function automatic int sfm_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/expu_ctrl_stage.sv
// One valid+tag cell of the EXPU row flow controller; loads whenever the stage can accept.
module expu_ctrl_stage
   import sfm_pkg::*;
#(
   parameter int TAG_WIDTH = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 valid_prev,
   input  logic [TAG_WIDTH-1:0] tag_prev,
   input  logic                 accept,
   output logic                 valid,
   output logic [TAG_WIDTH-1:0] tag,
   output logic                 enable
);

   // The row register only toggles on a real transfer; bubbles moving forward need no enable.
   assign enable = valid_prev & accept & ~clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tag   <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         tag   <= '0;
      end else if (accept) begin
         valid <= valid_prev;
         tag   <= tag_prev;
      end
   end

endmodule

// File: rtl/expu_pipe_ctrl.sv
// Valid/ready flow controller for one EXPU row: stage enables, bubble collapsing,
// sideband tag alignment, occupancy tracking and a drain sequence for vector close-out.
module expu_pipe_ctrl
   import sfm_pkg::*;
#(
   parameter  int NUM_REGS  = 0,
   parameter  int TAG_WIDTH = 1,
   localparam int CNT_WIDTH = sfm_clog2(NUM_REGS + 1),
   localparam int EN_WIDTH  = sfm_max(NUM_REGS, 1)
)(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [TAG_WIDTH-1:0] tag_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [TAG_WIDTH-1:0] tag_o,
   output logic [EN_WIDTH-1:0]  enable_o,
   output logic                 clear_o,
   input  logic                 drain_i,
   output logic                 drain_done_o,
   output logic [CNT_WIDTH-1:0] occupancy_o,
   output logic                 idle_o
);

   expu_ctrl_state_e     state_q, state_d;
   logic                 intake_en;
   logic                 push, pop;
   logic [CNT_WIDTH-1:0] occ_q, occ_d;

   assign intake_en = (state_q == RUN) & ~clear_i;
   assign clear_o   = clear_i;

   if (NUM_REGS == 0) begin : g_pass
      assign ready_o  = ready_i & intake_en;
      assign valid_o  = valid_i & intake_en;
      assign tag_o    = tag_i;
      assign enable_o = '0;
      assign push     = 1'b0;
      assign pop      = 1'b0;
   end else begin : g_pipe
      logic [NUM_REGS:0]                v;
      logic [NUM_REGS:0][TAG_WIDTH-1:0] tag;
      logic [NUM_REGS+1:1]              acc;

      assign v[0]   = valid_i & intake_en;
      assign tag[0] = tag_i;

      // A stage can accept when it is empty or its content moves on; this lets
      // empty stages in front of a stalled datum keep filling.
      always_comb begin
         acc[NUM_REGS+1] = ready_i;
         for (int k = NUM_REGS; k >= 1; k--) begin
            acc[k] = ~v[k] | acc[k+1];
         end
      end

      for (genvar k = 1; k <= NUM_REGS; k++) begin : g_stage
         expu_ctrl_stage #(
            .TAG_WIDTH (TAG_WIDTH)
         ) u_stage (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .clear      (clear_i),
            .valid_prev (v[k-1]),
            .tag_prev   (tag[k-1]),
            .accept     (acc[k]),
            .valid      (v[k]),
            .tag        (tag[k]),
            .enable     (enable_o[k-1])
         );
      end

      assign ready_o = acc[1] & intake_en;
      assign valid_o = v[NUM_REGS];
      assign tag_o   = tag[NUM_REGS];
      assign push    = v[0] & acc[1];
      assign pop     = v[NUM_REGS] & ready_i;
   end

   // Bubble collapsing never creates or destroys data, so occupancy only moves on push/pop.
   always_comb begin
      occ_d = occ_q;
      if (clear_i) begin
         occ_d = '0;
      end else if (push & ~pop) begin
         occ_d = occ_q + 1'b1;
      end else if (pop & ~push) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      drain_done_o = 1'b0;
      unique case (state_q)
         RUN:     if (drain_i) state_d = DRAIN;
         DRAIN:   if ((occ_q == '0) && !pop) state_d = DONE;
         DONE: begin
            drain_done_o = 1'b1;
            state_d      = RUN;
         end
         default: state_d = RUN;
      endcase
      if (clear_i) begin
         state_d      = RUN;
         drain_done_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         occ_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
      end
   end

   assign occupancy_o = occ_q;
   assign idle_o      = (occ_q == '0) & (state_q == RUN);

endmodule

// File: tb/tb_expu_pipe_ctrl.sv
// Bench for expu_pipe_ctrl: four depths share one stimulus stream; vector table,
// hand-written corner sequences and a randomized run against a queue-style model.
module tb_expu_pipe_ctrl;

   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear, valid, ready, drain;
   logic [TW-1:0] tag;

   logic          o3_ready, o3_valid, o3_clear, o3_done, o3_idle;
   logic [TW-1:0] o3_tag;
   logic [2:0]    o3_en;
   logic [1:0]    o3_occ;
   logic          o4_ready, o4_valid, o4_clear, o4_done, o4_idle;
   logic [TW-1:0] o4_tag;
   logic [3:0]    o4_en;
   logic [2:0]    o4_occ;
   logic          o0_ready, o0_valid, o0_clear, o0_done, o0_idle;
   logic [TW-1:0] o0_tag;
   logic [0:0]    o0_en;
   logic [0:0]    o0_occ;
   logic          o2_ready, o2_valid, o2_clear, o2_done, o2_idle;
   logic [TW-1:0] o2_tag;
   logic [1:0]    o2_en;
   logic [1:0]    o2_occ;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   expu_pipe_ctrl #(.NUM_REGS(3), .TAG_WIDTH(TW)) u_n3 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid), .ready_o(o3_ready),
      .tag_i(tag), .valid_o(o3_valid), .ready_i(ready), .tag_o(o3_tag), .enable_o(o3_en),
      .clear_o(o3_clear), .drain_i(drain), .drain_done_o(o3_done), .occupancy_o(o3_occ),
      .idle_o(o3_idle));

   expu_pipe_ctrl #(.NUM_REGS(4), .TAG_WIDTH(TW)) u_n4 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid), .ready_o(o4_ready),
      .tag_i(tag), .valid_o(o4_valid), .ready_i(ready), .tag_o(o4_tag), .enable_o(o4_en),
      .clear_o(o4_clear), .drain_i(drain), .drain_done_o(o4_done), .occupancy_o(o4_occ),
      .idle_o(o4_idle));

   expu_pipe_ctrl #(.NUM_REGS(0), .TAG_WIDTH(TW)) u_n0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid), .ready_o(o0_ready),
      .tag_i(tag), .valid_o(o0_valid), .ready_i(ready), .tag_o(o0_tag), .enable_o(o0_en),
      .clear_o(o0_clear), .drain_i(drain), .drain_done_o(o0_done), .occupancy_o(o0_occ),
      .idle_o(o0_idle));

   expu_pipe_ctrl #(.NUM_REGS(2), .TAG_WIDTH(TW)) u_n2 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .valid_i(valid), .ready_o(o2_ready),
      .tag_i(tag), .valid_o(o2_valid), .ready_i(ready), .tag_o(o2_tag), .enable_o(o2_en),
      .clear_o(o2_clear), .drain_i(drain), .drain_done_o(o2_done), .occupancy_o(o2_occ),
      .idle_o(o2_idle));

   typedef struct {
      logic          valid;
      logic          ready;
      logic [TW-1:0] tag;
      logic          exp_valid;
      logic [TW-1:0] exp_tag;
      logic [2:0]    exp_en;
      logic [1:0]    exp_occ;
      logic          exp_ready;
   } vec_t;

   vec_t vecs[$];

   // Reference model for the N=3 instance: slot array plus a simple mode number
   // (0 running, 1 draining, 2 done); z_state is the same mode for the N=0 instance.
   bit            m_v   [1:3];
   logic [TW-1:0] m_tag [1:3];
   int            m_state;
   int            z_state;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic r, input logic [TW-1:0] t,
                        input logic c, input logic d);
      valid = v;
      ready = r;
      tag   = t;
      clear = c;
      drain = d;
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int k = 1; k <= 3; k++) begin
         m_v[k]   = 1'b0;
         m_tag[k] = '0;
      end
      m_state = 0;
      z_state = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear = 1'b0;
      valid = 1'b0;
      ready = 1'b0;
      drain = 1'b0;
      tag   = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic vec_t mk(input logic v, input logic r, input logic [TW-1:0] t,
                               input logic ev, input logic [TW-1:0] et, input logic [2:0] en,
                               input logic [1:0] occ, input logic er);
      vec_t x;
      x.valid = v; x.ready = r; x.tag = t;
      x.exp_valid = ev; x.exp_tag = et; x.exp_en = en; x.exp_occ = occ; x.exp_ready = er;
      return x;
   endfunction

   // One cycle of the model: the front slot leaves on ready, then every datum steps
   // forward into a slot that is free after the move, then a new datum may enter.
   task automatic model_cycle();
      bit            nv [1:3];
      logic [TW-1:0] nt [1:3];
      logic [2:0]    en;
      bit            intake, rdy, zi;
      int            occ_now;
      occ_now = 0;
      for (int k = 1; k <= 3; k++) occ_now += int'(m_v[k]);
      intake = (m_state == 0) && !clear;
      nv  = m_v;
      nt  = m_tag;
      en  = '0;
      rdy = 1'b0;
      if (clear) begin
         for (int k = 1; k <= 3; k++) begin
            nv[k] = 1'b0;
            nt[k] = '0;
         end
      end else begin
         if (m_v[3] && ready) nv[3] = 1'b0;
         for (int k = 2; k >= 1; k--) begin
            if (nv[k] && !nv[k+1]) begin
               nv[k+1] = 1'b1;
               nt[k+1] = nt[k];
               nv[k]   = 1'b0;
               en[k]   = 1'b1;
            end
         end
         rdy = intake && !nv[1];
         if (rdy && valid) begin
            nv[1] = 1'b1;
            nt[1] = tag;
            en[0] = 1'b1;
         end
      end
      chk("rnd3 valid_o", 32'(o3_valid), 32'(m_v[3]));
      if (m_v[3]) chk("rnd3 tag_o", 32'(o3_tag), 32'(m_tag[3]));
      chk("rnd3 ready_o", 32'(o3_ready), 32'(rdy));
      chk("rnd3 enable_o", 32'(o3_en), 32'(en));
      chk("rnd3 occupancy_o", 32'(o3_occ), 32'(occ_now));
      chk("rnd3 idle_o", 32'(o3_idle), 32'(occ_now == 0 && m_state == 0));
      chk("rnd3 drain_done_o", 32'(o3_done), 32'(m_state == 2 && !clear));
      chk("rnd3 clear_o", 32'(o3_clear), 32'(clear));
      if (clear) m_state = 0;
      else if (m_state == 0) m_state = drain ? 1 : 0;
      else if (m_state == 1) m_state = (occ_now == 0) ? 2 : 1;
      else m_state = 0;
      m_v   = nv;
      m_tag = nt;

      zi = (z_state == 0) && !clear;
      chk("rnd0 valid_o", 32'(o0_valid), 32'(valid && zi));
      chk("rnd0 ready_o", 32'(o0_ready), 32'(ready && zi));
      chk("rnd0 tag_o", 32'(o0_tag), 32'(tag));
      chk("rnd0 enable_o", 32'(o0_en), 32'(0));
      chk("rnd0 idle_o", 32'(o0_idle), 32'(z_state == 0));
      chk("rnd0 drain_done_o", 32'(o0_done), 32'(z_state == 2 && !clear));
      if (clear) z_state = 0;
      else if (z_state == 0) z_state = drain ? 1 : 0;
      else if (z_state == 1) z_state = 2;
      else z_state = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [TW-1:0] got[$];
      int            pulses;
      int            pulse_cyc;

      do_reset();

      // Reset state
      drive(0, 0, 0, 0, 0);
      chk("rst valid_o", 32'(o3_valid), 32'(0));
      chk("rst tag_o", 32'(o3_tag), 32'(0));
      chk("rst enable_o", 32'(o3_en), 32'(0));
      chk("rst clear_o", 32'(o3_clear), 32'(0));
      chk("rst drain_done_o", 32'(o3_done), 32'(0));
      chk("rst occupancy_o", 32'(o3_occ), 32'(0));
      chk("rst idle_o", 32'(o3_idle), 32'(1));
      chk("rst ready_o", 32'(o3_ready), 32'(1));
      chk("rst n4 valid_o", 32'(o4_valid), 32'(0));
      chk("rst n0 ready_o", 32'(o0_ready), 32'(0));
      tick();

      // Streaming: 10 data at full rate, latency 3, then the tail flushes
      for (int c = 0; c < 14; c++) begin
         logic [2:0] en;
         int         occ;
         en  = '0;
         occ = 0;
         for (int j = 0; j < 3; j++) if (c - j >= 0 && c - j < 10) en[j] = 1'b1;
         for (int i = 0; i < 10; i++) if (i + 1 <= c && c <= i + 3) occ++;
         vecs.push_back(mk(c < 10, 1, TW'(c), c >= 3 && c < 13, TW'(c - 3), en, 2'(occ), 1));
      end
      // Stall on a full pipe for 5 cycles, then release
      vecs.push_back(mk(1, 0, 4'hA, 0, 0,    3'b001, 0, 1));
      vecs.push_back(mk(1, 0, 4'hB, 0, 0,    3'b011, 1, 1));
      vecs.push_back(mk(1, 0, 4'hC, 0, 0,    3'b111, 2, 1));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 4'hD, 1, 4'hA, 3'b000, 3, 0));
      vecs.push_back(mk(1, 1, 4'hD, 1, 4'hA, 3'b111, 3, 1));
      vecs.push_back(mk(0, 1, 0,    1, 4'hB, 3'b110, 3, 1));
      vecs.push_back(mk(0, 1, 0,    1, 4'hC, 3'b100, 2, 1));
      vecs.push_back(mk(0, 1, 0,    1, 4'hD, 3'b000, 1, 1));
      vecs.push_back(mk(0, 1, 0,    0, 0,    3'b000, 0, 1));

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].ready, vecs[i].tag, 0, 0);
         chk("vec valid_o", 32'(o3_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) chk("vec tag_o", 32'(o3_tag), 32'(vecs[i].exp_tag));
         chk("vec enable_o", 32'(o3_en), 32'(vecs[i].exp_en));
         chk("vec occupancy_o", 32'(o3_occ), 32'(vecs[i].exp_occ));
         chk("vec ready_o", 32'(o3_ready), 32'(vecs[i].exp_ready));
         tick();
      end

      // N=4 bubble collapse: a lone datum runs to the last stage under stall
      do_reset();
      drive(1, 0, 4'h5, 0, 0);
      chk("bub en c0", 32'(o4_en), 32'(4'b0001));
      tick();
      for (int c = 1; c <= 3; c++) begin
         drive(0, 0, 0, 0, 0);
         chk("bub en walk", 32'(o4_en), 32'(4'b0001 << c));
         tick();
      end
      drive(1, 0, 4'h6, 0, 0);
      chk("bub valid_o", 32'(o4_valid), 32'(1));
      chk("bub tag_o", 32'(o4_tag), 32'(5));
      chk("bub ready_o", 32'(o4_ready), 32'(1));
      chk("bub en c4", 32'(o4_en), 32'(4'b0001));
      tick();
      drive(0, 0, 0, 0, 0);
      chk("bub en c5", 32'(o4_en), 32'(4'b0010));
      tick();
      drive(0, 0, 0, 0, 0);
      chk("bub en c6", 32'(o4_en), 32'(4'b0100));
      tick();
      drive(0, 0, 0, 0, 0);
      chk("bub en stop", 32'(o4_en), 32'(4'b0000));
      chk("bub occupancy_o", 32'(o4_occ), 32'(2));
      chk("bub tag hold", 32'(o4_tag), 32'(5));
      tick();

      // Clear with two in flight
      do_reset();
      drive(1, 1, 4'h1, 0, 0);
      tick();
      drive(1, 1, 4'h2, 0, 0);
      tick();
      drive(0, 1, 0, 1, 0);
      chk("clr occupancy before", 32'(o3_occ), 32'(2));
      chk("clr clear_o", 32'(o3_clear), 32'(1));
      chk("clr enable_o", 32'(o3_en), 32'(0));
      chk("clr ready_o", 32'(o3_ready), 32'(0));
      tick();
      drive(0, 1, 0, 0, 0);
      chk("clr occupancy after", 32'(o3_occ), 32'(0));
      chk("clr tag_o", 32'(o3_tag), 32'(0));
      chk("clr idle_o", 32'(o3_idle), 32'(1));
      for (int c = 0; c < 4; c++) begin
         drive(0, 1, 0, 0, 0);
         chk("clr valid_o", 32'(o3_valid), 32'(0));
         chk("clr no drain_done", 32'(o3_done), 32'(0));
         tick();
      end

      // Drain with three in flight
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, TW'(i + 1), 0, 0);
         tick();
      end
      got.delete();
      pulses    = 0;
      pulse_cyc = -1;
      drive(0, 1, 0, 0, 1);
      chk("drn occupancy full", 32'(o3_occ), 32'(3));
      if (o3_valid) got.push_back(o3_tag);
      tick();
      for (int c = 4; c < 10; c++) begin
         drive(c < 7, 1, 4'hF, 0, 0);
         if (c < 7) chk("drn ready_o blocked", 32'(o3_ready), 32'(0));
         if (o3_valid) got.push_back(o3_tag);
         if (o3_done) begin
            pulses++;
            pulse_cyc = c;
         end
         tick();
      end
      chk("drn output count", 32'(got.size()), 32'(3));
      for (int i = 0; i < got.size() && i < 3; i++) chk("drn output order", 32'(got[i]), 32'(i + 1));
      chk("drn pulse count", 32'(pulses), 32'(1));
      chk("drn pulse cycle", 32'(pulse_cyc), 32'(7));
      drive(0, 1, 0, 0, 0);
      chk("drn idle_o", 32'(o3_idle), 32'(1));
      chk("drn ready_o", 32'(o3_ready), 32'(1));
      tick();

      // N=0 combinational mirror
      do_reset();
      for (int c = 0; c < 12; c++) begin
         logic v, r, cl;
         logic [TW-1:0] t;
         v  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         cl = (c == 5);
         t  = TW'($urandom_range(0, 15));
         drive(v, r, t, cl, 0);
         chk("pass valid_o", 32'(o0_valid), 32'(v & ~cl));
         chk("pass ready_o", 32'(o0_ready), 32'(r & ~cl));
         chk("pass tag_o", 32'(o0_tag), 32'(t));
         chk("pass enable_o", 32'(o0_en), 32'(0));
         chk("pass occupancy_o", 32'(o0_occ), 32'(0));
         tick();
      end

      // Reset mid-stream at N=2
      do_reset();
      for (int c = 0; c < 3; c++) begin
         drive(1, 1, TW'(c + 1), 0, 0);
         if (c == 2) begin
            chk("mid valid_o", 32'(o2_valid), 32'(1));
            chk("mid tag_o", 32'(o2_tag), 32'(1));
         end
         tick();
      end
      rst_n = 1'b0;
      drive(0, 1, 0, 0, 0);
      chk("mid rst valid_o", 32'(o2_valid), 32'(0));
      chk("mid rst tag_o", 32'(o2_tag), 32'(0));
      chk("mid rst enable_o", 32'(o2_en), 32'(0));
      chk("mid rst occupancy_o", 32'(o2_occ), 32'(0));
      chk("mid rst idle_o", 32'(o2_idle), 32'(1));
      chk("mid rst drain_done_o", 32'(o2_done), 32'(0));
      chk("mid rst n3 valid_o", 32'(o3_valid), 32'(0));
      tick();

      // Randomized run against the model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, TW'($urandom_range(0, 15)),
               $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0);
         model_cycle();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
